// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: valid/ready UART transmitter, configurable data width, stop bits and parity.
// Define UART_TX_PARITY_EN to add the parity bit after the data bits.
module uart_tx_cfg #(
  parameter int CLK_FREQ   = 5_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif
  state_e                 state_q, state_d;
  logic [CW-1:0]          baud_q, baud_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d, done_q, done_d;
  logic                   bit_end, last_data, last_stop, accept;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif
  assign bit_end    = baud_q == CW'(CPB - 1);
  assign last_data  = bit_q == 4'(DATA_BITS - 1);
  assign last_stop  = bit_q == 4'(STOP_BITS - 1);
  assign tx_ready   = !rst && (state_q == IDLE || (state_q == STOP && last_stop && bit_end));
  assign accept     = tx_valid && tx_ready;
  assign tx         = tx_q;
  assign busy       = state_q != IDLE;
  assign frame_done = done_q;
  always_comb begin
    state_d = state_q;
    baud_d  = (state_q == IDLE || accept || bit_end) ? '0 : baud_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:  if (accept) state_d = START;
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA:  if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_d   = last_data ? 4'd0 : bit_q + 4'd1;
`ifdef UART_TX_PARITY_EN
        if (last_data) state_d = PARITY;
`else
        if (last_data) state_d = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP:  if (bit_end) begin
        bit_d = last_stop ? 4'd0 : bit_q + 4'd1;
        if (last_stop) begin
          done_d  = 1'b1;
          state_d = accept ? START : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
    par_d = accept ? (^tx_data) ^ (PARITY_ODD != 0) : par_q;
    tx_d  = state_d == START  ? 1'b0 :
            state_d == DATA   ? shift_d[0] :
            state_d == PARITY ? par_d : 1'b1;
`else
    tx_d  = state_d == START ? 1'b0 :
            state_d == DATA  ? shift_d[0] : 1'b1;
`endif
  end
  // tx follows the next state so the line changes on the same edge as the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: scoreboard bench for uart_tx_cfg on three configurations (8N1/8E, 7-bit 2-stop, 8-bit odd).
// Honours UART_TX_PARITY_EN when defined for the whole build.
module tb_uart_tx_cfg;
  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] valid = '0;
  logic [7:0] wdata = '0;
  logic [2:0] txv, busyv, donev, rdyv;
  logic [1:0] sel = '0;
  int         cyc = 0, n_chk = 0, n_fail = 0, rx_start = 0;
  logic [7:0] sbq[$];
  wire tx_m   = txv[sel];
  wire busy_m = busyv[sel];
  wire done_m = donev[sel];
  wire rdy_m  = rdyv[sel];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_cfg #(.CLK_FREQ(5_000_000), .BAUD_RATE(500_000), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
    .clk(clk), .rst(rst), .tx_data(wdata), .tx_valid(valid[0]), .tx_ready(rdyv[0]),
    .tx(txv[0]), .busy(busyv[0]), .frame_done(donev[0]));
  uart_tx_cfg #(.CLK_FREQ(5_000_000), .BAUD_RATE(500_000), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1)) u_b (
    .clk(clk), .rst(rst), .tx_data(wdata[6:0]), .tx_valid(valid[1]), .tx_ready(rdyv[1]),
    .tx(txv[1]), .busy(busyv[1]), .frame_done(donev[1]));
  uart_tx_cfg #(.CLK_FREQ(5_000_000), .BAUD_RATE(500_000), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) u_c (
    .clk(clk), .rst(rst), .tx_data(wdata), .tx_valid(valid[2]), .tx_ready(rdyv[2]),
    .tx(txv[2]), .busy(busyv[2]), .frame_done(donev[2]));

  function automatic int db(int d); return d == 1 ? 7 : 8; endfunction
  function automatic int sb(int d); return d == 1 ? 2 : 1; endfunction
  function automatic int od(int d); return d == 0 ? 0 : 1; endfunction
  function automatic int flen(int d); return (1 + db(d) + P + sb(d)) * CPB; endfunction

  function automatic logic ebit(int d, logic [7:0] w, int i);
    if (i == 0) return 1'b0;
    if (i <= db(d)) return w[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == db(d) + 1) return (^w) ^ (od(d) != 0);
`endif
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input int d, input logic [7:0] w, input bit hold);
    int t = 0;
    @(negedge clk);
    wdata = w;
    valid[d] = 1'b1;
    while (!rdyv[d] && t < 500) begin @(negedge clk); t++; end
    check("send_wait_timeout", 32'(t >= 500), 0);
    @(posedge clk);
    sbq.push_back(d == 1 ? (w & 8'h7F) : w);
    @(negedge clk);
    if (!hold) valid[d] = 1'b0;
  endtask

  task automatic wait_low(output bit ok);
    int t = 0;
    while (tx_m !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
    ok = t < 2000;
    check("start_wait_timeout", 32'(!ok), 0);
  endtask

  task automatic rx_frame(input int d);
    bit ok;
    logic [7:0] w;
    logic [9:0] s;
    int nb = 1 + db(d) + P + sb(d);
    int rdy_cnt = 0;
    logic lastr = 1'b0, busy_all = 1'b1, done_any = 1'b0;
    wait_low(ok);
    if (!ok) return;
    rx_start = cyc;
    check("scoreboard_empty", 32'(sbq.size() == 0), 0);
    w = sbq.size() ? sbq.pop_front() : 8'h00;
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < CPB; j++) begin
        s[j] = tx_m;
        if (!busy_m) busy_all = 1'b0;
        if (done_m && (i != 0 || j != 0)) done_any = 1'b1;
        if (rdy_m) rdy_cnt++;
        lastr = rdy_m;
        @(negedge clk);
      end
      check($sformatf("dut%0d_w%0h_bit%0d", d, w, i), s, {10{ebit(d, w, i)}});
    end
    check("busy_in_frame", busy_all, 1);
    check("done_early", done_any, 0);
    check("ready_count", rdy_cnt, 1);
    check("ready_last_cycle", lastr, 1);
    check("frame_done_pulse", done_m, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"}, tx_m, 1);
    check({tag, "_busy"}, busy_m, 0);
    check({tag, "_ready"}, rdy_m, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s1;
    bit ok;
    logic [29:0] v;
    repeat (3) @(negedge clk);
    check("rst_tx", tx_m, 1);
    check("rst_busy", busy_m, 0);
    check("rst_done", done_m, 0);
    check("rst_ready", rdy_m, 0);
    rst = 1'b0;
    #1 check("ready_after_rst", rdy_m, 1);
    // single word on each configuration
    sel = 0;
    fork send(0, 8'h55, 0); rx_frame(0); join
    check_idle("after_55");
    sel = 1;
    fork send(1, 8'h41, 0); rx_frame(1); join
    check_idle("after_41");
    sel = 0;
    fork send(0, 8'hA7, 0); rx_frame(0); join
    sel = 2;
    fork send(2, 8'hA7, 0); rx_frame(2); join
    check_idle("after_a7");
    // back-to-back with valid held high
    sel = 0;
    fork
      begin send(0, 8'h12, 1); send(0, 8'h34, 0); end
      begin
        rx_frame(0);
        s1 = rx_start;
        check("b2b_busy_between", busy_m, 1);
        rx_frame(0);
        check("b2b_start_gap", rx_start - s1, flen(0));
      end
    join
    check_idle("after_b2b");
    // reset in the middle of a frame
    fork
      send(0, 8'h3C, 0);
      begin
        wait_low(ok);
        repeat (35) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx", tx_m, 1);
        check("midrst_busy", busy_m, 0);
        check("midrst_done", done_m, 0);
        rst = 1'b0;
      end
    join
    sbq.delete();
    v = '0;
    for (int i = 0; i < 30; i++) begin @(negedge clk); v[i] = tx_m | done_m; end
    check("midrst_quiet", v, 30'h3FFFFFFF);
    fork send(0, 8'hC3, 0); rx_frame(0); join
    // backpressure: a valid pulse while busy must be ignored
    fork
      send(0, 8'h5A, 0);
      rx_frame(0);
      begin
        repeat (40) @(negedge clk);
        wdata = 8'hFF;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
      end
    join
    check_idle("after_bp");
    check("bp_queue", sbq.size(), 0);
    v = '0;
    for (int i = 0; i < 30; i++) begin v[i] = tx_m & !busy_m; @(negedge clk); end
    check("bp_line_idle", v, 30'h3FFFFFFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
